branch_predictor_unit: RTL and testbench
========================================

BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the number of predictor entries; it must be a power of two, 4 to 256.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the PC/operand width.
REQ-003 Port CLK  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port RESET  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 Port if_pc  in  XLEN  fetch-stage PC to predict.
REQ-006 Port pred_taken  out  1  prediction for if_pc: 1 = redirect fetch to pred_target.
REQ-007 Port pred_target  out  XLEN  predicted target for if_pc.
REQ-008 Port ex_valid  in  1  an instruction is resolving in EX this cycle.
REQ-009 Port ex_branch, ex_jump  in  1 each  the EX instruction is a conditional branch or a JAL/JALR.
REQ-010 Port ex_pc  in  XLEN  PC of the EX instruction.
REQ-011 Port ex_func3  in  3  RV32 branch func3.
REQ-012 Port ex_data1, ex_data2  in  XLEN each  rs1/rs2 operand values.
REQ-013 Port ex_target  in  XLEN  computed target (ALU result).
REQ-014 Port ex_pred_taken, ex_pred_target  in  1 / XLEN  prediction carried down the pipeline with the EX instruction.
REQ-015 Port flush  out  1  the EX instruction was mispredicted; squash IF/ID.
REQ-016 Port redirect_pc  out  XLEN  correct next PC; valid when flush=1.

Function
REQ-017 The table SHALL hold ENTRIES entries of {valid, tag, target[XLEN], ctr[2]}; index = pc[log2(ENTRIES)+1:2]; tag = pc[XLEN-1:log2(ENTRIES)+2].
REQ-018 Lookup SHALL be combinational with zero latency: hit = valid && tag match; pred_taken = hit && ctr>=2; pred_target = hit ? target : if_pc+4.
REQ-019 Actual outcome: ex_branch=1 -> func3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; 010/011 -> not taken. Otherwise ex_jump=1 -> taken. ex_branch SHALL take priority when both ex_branch and ex_jump are 1.
REQ-020 flush (combinational, same cycle) SHALL equal ex_valid && (ex_branch||ex_jump) && (actual != ex_pred_taken || (actual && ex_target != ex_pred_target)).
REQ-021 redirect_pc SHALL be ex_target when actual taken, else ex_pc+4 (mod 2^XLEN).
REQ-022 Update SHALL occur on the clock edge when ex_valid && (ex_branch||ex_jump) && !RESET; no other condition modifies the table.
REQ-023 On a hit with actual taken: ctr saturating increment (max 3); target <= ex_target.
REQ-024 On a hit with actual not taken: ctr saturating decrement (min 0); target unchanged.
REQ-025 On a miss with actual taken: allocate (overwrite) the indexed entry: valid=1, new tag, target=ex_target, ctr=2 (3 for jumps).
REQ-026 On a miss with actual not taken: no allocation.
REQ-027 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents (no bypass).
REQ-028 When ex_valid=0, or ex_branch=ex_jump=0: flush=0 and no state change.

Reset
REQ-029 While RESET=1 at an edge: all valid<=0, all ctr<=1; pending updates that cycle SHALL be discarded.
REQ-030 After reset: pred_taken=0, pred_target=if_pc+4. flush SHALL be forced to 0 while RESET=1.

Configuration
REQ-031 With BPU_PERF_CNT_EN defined: outputs perf_branches and perf_mispredicts, 32 bits each, SHALL be present; they count update events and flush cycles respectively, reset to 0, and wrap from 2^32-1 to 0.
REQ-032 Without BPU_PERF_CNT_EN: both ports and their counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-034 BEQ at ex_pc=0x100, data1=data2=5, target 0x80, pred_taken=0 -> flush=1, redirect_pc=0x80; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
REQ-035 Same branch resolved not taken twice (ctr 2->1->0) -> flush=1 on the first; afterwards the lookup gives pred_taken=0.
REQ-036 BLT with data1=0xFFFFFFFF, data2=1 -> taken; BLTU with the same operands -> not taken; func3=010 -> not taken, no allocation.
REQ-037 ENTRIES=16: taken branches at 0x100 and 0x140 (same index) -> second evicts first; lookup at 0x100 misses.
REQ-038 RESET asserted during an update cycle -> table stays cleared, flush=0; with BPU_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_unit
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                counters, zero-latency lookup for fetch and branch
//                resolution / mispredict detection for the EX stage.
//                Optional performance counters are enabled by defining
//                the macro BPU_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_unit #(
   parameter int ENTRIES = 16,
   parameter int XLEN    = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   // fetch-side lookup
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   // EX-side resolution
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jump,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [2:0]      ex_func3,
   input  logic [XLEN-1:0] ex_data1,
   input  logic [XLEN-1:0] ex_data2,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc
`ifdef BPU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = XLEN - IDXW - 2;

   logic            tbl_valid  [ENTRIES];
   logic [TAGW-1:0] tbl_tag    [ENTRIES];
   logic [XLEN-1:0] tbl_target [ENTRIES];
   logic [1:0]      tbl_ctr    [ENTRIES];

   logic [IDXW-1:0] if_idx, ex_idx;
   logic [TAGW-1:0] if_tag, ex_tag;
   logic            if_hit, ex_hit;
   logic            actual_taken;
   logic            update_en;
   logic            unused_ok;

   assign if_idx = if_pc[IDXW+1:2];
   assign if_tag = if_pc[XLEN-1:IDXW+2];
   assign ex_idx = ex_pc[IDXW+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDXW+2];

   // Word-aligned PCs: the low two bits never select an entry.
   assign unused_ok = &{1'b0, if_pc[1:0], ex_pc[1:0]};

   // Lookup reads the array directly, so a same-cycle update is not visible.
   assign if_hit      = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
   assign pred_taken  = if_hit && tbl_ctr[if_idx][1];
   assign pred_target = if_hit ? tbl_target[if_idx] : if_pc + XLEN'(4);

   assign ex_hit    = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
   assign update_en = ex_valid && (ex_branch || ex_jump) && !RESET;

   // Resolve the real outcome; conditional branch wins over jump.
   always_comb begin
      actual_taken = 1'b0;
      if (ex_branch) begin
         case (ex_func3)
            3'b000:  actual_taken = (ex_data1 == ex_data2);
            3'b001:  actual_taken = (ex_data1 != ex_data2);
            3'b100:  actual_taken = ($signed(ex_data1) <  $signed(ex_data2));
            3'b101:  actual_taken = ($signed(ex_data1) >= $signed(ex_data2));
            3'b110:  actual_taken = (ex_data1 <  ex_data2);
            3'b111:  actual_taken = (ex_data1 >= ex_data2);
            default: actual_taken = 1'b0;
         endcase
      end else if (ex_jump) begin
         actual_taken = 1'b1;
      end
   end

   assign flush = update_en &&
                  ((actual_taken != ex_pred_taken) ||
                   (actual_taken && (ex_target != ex_pred_target)));

   assign redirect_pc = actual_taken ? ex_target : ex_pc + XLEN'(4);

   // Table maintenance: clear on reset, train/allocate on resolved control flow.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_valid[i] <= 1'b0;
            tbl_ctr[i]   <= 2'd1;
         end
      end else if (update_en) begin
         if (ex_hit) begin
            if (actual_taken) begin
               if (tbl_ctr[ex_idx] != 2'd3)
                  tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + 2'd1;
               tbl_target[ex_idx] <= ex_target;
            end else if (tbl_ctr[ex_idx] != 2'd0) begin
               tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - 2'd1;
            end
         end else if (actual_taken) begin
            tbl_valid[ex_idx]  <= 1'b1;
            tbl_tag[ex_idx]    <= ex_tag;
            tbl_target[ex_idx] <= ex_target;
            tbl_ctr[ex_idx]    <= ex_branch ? 2'd2 : 2'd3;
         end
      end
   end

`ifdef BPU_PERF_CNT_EN
   // Event counters: resolved control-flow instructions and mispredict flushes.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         perf_branches    <= 32'd0;
         perf_mispredicts <= 32'd0;
      end else begin
         if (update_en) perf_branches    <= perf_branches + 32'd1;
         if (flush)     perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_unit
//  Description : Directed, table-driven self-checking bench for
//                branch_predictor_unit (ENTRIES=16, XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_unit;

   localparam int XLEN = 32;

   logic            CLK = 1'b0;
   logic            RESET;
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid, ex_branch, ex_jump;
   logic [XLEN-1:0] ex_pc;
   logic [2:0]      ex_func3;
   logic [XLEN-1:0] ex_data1, ex_data2, ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
`ifdef BPU_PERF_CNT_EN
   logic [31:0]     perf_branches, perf_mispredicts;
`endif

   branch_predictor_unit #(.ENTRIES(16), .XLEN(XLEN)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_branch      (ex_branch),
      .ex_jump        (ex_jump),
      .ex_pc          (ex_pc),
      .ex_func3       (ex_func3),
      .ex_data1       (ex_data1),
      .ex_data2       (ex_data2),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .flush          (flush),
      .redirect_pc    (redirect_pc)
`ifdef BPU_PERF_CNT_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] if_pc;
      logic        v, br, jp;
      logic [31:0] pc;
      logic [2:0]  f3;
      logic [31:0] d1, d2, tgt;
      logic        ept;
      logic [31:0] eptgt;
      logic        x_pt;
      logic [31:0] x_ptgt;
      logic        x_flush;
      logic [31:0] x_redir;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [31:0] ipc, input logic v, input logic br,
                               input logic jp, input logic [31:0] pc, input logic [2:0] f3,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] tgt, input logic ept,
                               input logic [31:0] eptgt, input logic xpt,
                               input logic [31:0] xptgt, input logic xfl,
                               input logic [31:0] xrd);
      vec_t r;
      r.if_pc = ipc; r.v = v; r.br = br; r.jp = jp; r.pc = pc; r.f3 = f3;
      r.d1 = d1; r.d2 = d2; r.tgt = tgt; r.ept = ept; r.eptgt = eptgt;
      r.x_pt = xpt; r.x_ptgt = xptgt; r.x_flush = xfl; r.x_redir = xrd;
      return r;
   endfunction

   // Idle EX stage (ex_pc=0x200, not taken -> redirect 0x204) with a lookup.
   function automatic vec_t idle(input logic [31:0] ipc, input logic xpt,
                                 input logic [31:0] xptgt);
      return mk(ipc, 1'b0, 1'b0, 1'b0, 32'h200, 3'b000, 32'h0, 32'h0, 32'h0,
                1'b0, 32'h0, xpt, xptgt, 1'b0, 32'h204);
   endfunction

   task automatic drive(input vec_t t);
      if_pc = t.if_pc; ex_valid = t.v; ex_branch = t.br; ex_jump = t.jp;
      ex_pc = t.pc; ex_func3 = t.f3; ex_data1 = t.d1; ex_data2 = t.d2;
      ex_target = t.tgt; ex_pred_taken = t.ept; ex_pred_target = t.eptgt;
   endtask

   initial begin
      //              if_pc      v br jp ex_pc        f3      d1            d2            tgt       ept eptgt    | pt ptgt      fl redir
      vecs[0]  = idle(32'h100, 0, 32'h104);
      vecs[1]  = mk(32'h100, 1,1,0, 32'h100, 3'b000, 32'd5,        32'd5,        32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80);
      vecs[2]  = idle(32'h100, 1, 32'h80);
      vecs[3]  = mk(32'h100, 1,1,0, 32'h100, 3'b000, 32'd5,        32'd6,        32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104);
      vecs[4]  = mk(32'h100, 1,1,0, 32'h100, 3'b000, 32'd5,        32'd6,        32'h80,  0, 32'h104, 0, 32'h80,  0, 32'h104);
      vecs[5]  = idle(32'h100, 0, 32'h80);
      vecs[6]  = mk(32'h100, 1,1,0, 32'h100, 3'b001, 32'd1,        32'd2,        32'h80,  0, 32'h104, 0, 32'h80,  1, 32'h80);
      vecs[7]  = idle(32'h100, 0, 32'h80);
      vecs[8]  = mk(32'h140, 1,0,1, 32'h140, 3'b000, 32'd0,        32'd0,        32'h300, 0, 32'h144, 0, 32'h144, 1, 32'h300);
      vecs[9]  = idle(32'h100, 0, 32'h104);
      vecs[10] = idle(32'h140, 1, 32'h300);
      vecs[11] = mk(32'h104, 1,1,0, 32'h104, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h40,  1, 32'h40,  0, 32'h108, 0, 32'h40);
      vecs[12] = idle(32'h104, 1, 32'h40);
      vecs[13] = mk(32'h108, 1,1,0, 32'h108, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h50,  0, 32'h10C, 0, 32'h10C, 0, 32'h10C);
      vecs[14] = mk(32'h108, 1,1,0, 32'h108, 3'b010, 32'd0,        32'd0,        32'h50,  1, 32'h50,  0, 32'h10C, 1, 32'h10C);
      vecs[15] = idle(32'h108, 0, 32'h10C);
      vecs[16] = mk(32'h104, 1,1,0, 32'h104, 3'b111, 32'hFFFFFFFF, 32'd1,        32'h60,  1, 32'h40,  1, 32'h40,  1, 32'h60);
      vecs[17] = idle(32'h104, 1, 32'h60);
      vecs[18] = mk(32'h10C, 1,1,1, 32'h10C, 3'b000, 32'd1,        32'd2,        32'h700, 0, 32'h110, 0, 32'h110, 0, 32'h110);
      vecs[19] = idle(32'h10C, 0, 32'h110);
      vecs[20] = mk(32'h10C, 0,1,0, 32'h10C, 3'b000, 32'd3,        32'd3,        32'h110, 0, 32'h110, 0, 32'h110, 0, 32'h110);
      vecs[21] = idle(32'h10C, 0, 32'h110);
      vecs[22] = mk(32'h110, 1,1,0, 32'h110, 3'b101, 32'd1,        32'hFFFFFFFF, 32'h20,  0, 32'h114, 0, 32'h114, 1, 32'h20);
      vecs[23] = idle(32'h110, 1, 32'h20);
      vecs[24] = mk(32'h200, 1,1,0, 32'hFFFFFFFC, 3'b000, 32'd0,   32'd1,        32'h20,  0, 32'h0,   0, 32'h204, 0, 32'h0);
      vecs[25] = mk(32'h140, 1,0,1, 32'h140, 3'b000, 32'd0,        32'd0,        32'h300, 1, 32'h300, 1, 32'h300, 0, 32'h300);
      vecs[26] = idle(32'h140, 1, 32'h300);

      // Reset sequence
      RESET = 1'b1;
      drive(idle(32'h100, 0, 32'h104));
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
`ifdef BPU_PERF_CNT_EN
      #1;
      check("perf_branches_rst", perf_branches, 32'd0);
      check("perf_mispredicts_rst", perf_mispredicts, 32'd0);
`endif

      // Table-driven vectors: checks happen before the edge that applies the update.
      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d_pred_taken", i),  {31'd0, pred_taken}, {31'd0, vecs[i].x_pt});
         check($sformatf("v%0d_pred_target", i), pred_target,         vecs[i].x_ptgt);
         check($sformatf("v%0d_flush", i),       {31'd0, flush},      {31'd0, vecs[i].x_flush});
         check($sformatf("v%0d_redirect", i),    redirect_pc,         vecs[i].x_redir);
      end

      // Reset asserted during a mispredicted, taken branch at 0x114.
      @(negedge CLK);
      drive(mk(32'h140, 1,1,0, 32'h114, 3'b000, 32'd9, 32'd9, 32'h900, 0, 32'h118,
               0, 32'h0, 0, 32'h0));
      RESET = 1'b1;
      #1;
      check("rst_upd_flush", {31'd0, flush}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      drive(idle(32'h140, 0, 32'h144));
      #1;
      check("rst_clear_140_taken",  {31'd0, pred_taken}, 32'd0);
      check("rst_clear_140_target", pred_target, 32'h144);
      if_pc = 32'h114;
      #1;
      check("rst_drop_114_taken",  {31'd0, pred_taken}, 32'd0);
      check("rst_drop_114_target", pred_target, 32'h118);
      if_pc = 32'h100;
      #1;
      check("rst_100_taken",  {31'd0, pred_taken}, 32'd0);
      check("rst_100_target", pred_target, 32'h104);
`ifdef BPU_PERF_CNT_EN
      check("perf_branches_after_rst", perf_branches, 32'd0);
      check("perf_mispredicts_after_rst", perf_mispredicts, 32'd0);
      // One mispredicted taken jump: both counters step by one.
      drive(mk(32'h100, 1,0,1, 32'h180, 3'b000, 32'd0, 32'd0, 32'h40, 0, 32'h184,
               0, 32'h0, 0, 32'h0));
      @(negedge CLK);
      drive(idle(32'h100, 0, 32'h104));
      #1;
      check("perf_branches_one", perf_branches, 32'd1);
      check("perf_mispredicts_one", perf_mispredicts, 32'd1);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
